// File: rtl/cfg_master_pkg.sv
// Shared types and constants for the cfg_master initiator.
package pkg_cfg_master;

    // Burst sequencing states
    typedef enum logic [2:0] {
        Idle,
        WrReq,
        RdReq,
        RdWait,
        Rsp
    } state_e;

    // Burst length field (beats minus one) at its default width
    typedef logic [7:0] cfg_len_t;

    // Pattern the config unit returns for an illegal address; also used as abort data
    localparam logic [31:0] CFG_ILLEGAL_DATA = 32'hdeadda7a;

    // Byte distance between consecutive config words
    localparam int CFG_ADDR_STRIDE = 4;

endpackage

// File: rtl/cfg_master_watchdog.sv
// Stall watchdog for cfg_master: counts consecutive stalled cycles and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES. Only instantiated when
// CFG_MASTER_TIMEOUT_EN is defined.
module cfg_master_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic count_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Expire on the stalled cycle that would make the count reach the limit
    assign expire_o = count_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Stall counter: restarts on progress or expiry, holds when neither counting nor cleared
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i || expire_o) begin
            cnt_q <= '0;
        end else if (count_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/cfg_master.sv
// cfg_master: turns one burst command into single-word cfg transactions with
// auto-incrementing addresses, one transaction in flight at a time.
// Optional watchdog abort is enabled by defining CFG_MASTER_TIMEOUT_EN.
module cfg_master
    import pkg_cfg_master::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_last_o,
    output logic                  rsp_err_o,
    output logic                  cfg_req_o,
    input  logic                  cfg_gnt_i,
    output logic                  cfg_wen_o,
    output logic [ADDR_WIDTH-1:0] cfg_addr_o,
    output logic [DATA_WIDTH-1:0] cfg_wdata_o,
    input  logic [DATA_WIDTH-1:0] cfg_rdata_i,
    input  logic                  cfg_rvalid_i,
    output logic                  busy_o
);

    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(CFG_ADDR_STRIDE);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_last_q, rsp_last_d;
    logic                  expire;

`ifdef CFG_MASTER_TIMEOUT_EN
    logic wd_count;
    logic wd_hold;
    logic rsp_err_q;

    // Stalled means a request or read return is outstanding with no progress this cycle;
    // a write waiting for upstream data is neither stalled nor progress
    assign wd_count = ((state_q == WrReq) && wdata_valid_i && !cfg_gnt_i) ||
                      ((state_q == RdReq) && !cfg_gnt_i) ||
                      ((state_q == RdWait) && !cfg_rvalid_i);
    assign wd_hold  = (state_q == WrReq) && !wdata_valid_i;

    cfg_master_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .count_i (wd_count),
        .clear_i (!wd_count && !wd_hold),
        .expire_o(expire)
    );

    // Abort flag: set by the watchdog, dropped once the burst is over
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_err_q <= 1'b0;
        end else if (expire) begin
            rsp_err_q <= 1'b1;
        end else if (state_q == Idle) begin
            rsp_err_q <= 1'b0;
        end
    end

    assign rsp_err_o = (state_q == Rsp) && rsp_err_q;
`else
    assign expire    = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    // Burst state, address, remaining-beat counter and response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= Idle;
            addr_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_last_q <= rsp_last_d;
        end
    end

    // Next-state and handshake outputs; abort on watchdog expiry only when no progress was made
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_last_d    = rsp_last_q;
        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        rsp_valid_o   = 1'b0;
        cfg_req_o     = 1'b0;
        cfg_wen_o     = 1'b0;
        cfg_addr_o    = '0;
        cfg_wdata_o   = '0;

        unique case (state_q)
            Idle: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    addr_d     = {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    cnt_d      = cmd_len_i;
                    rsp_data_d = '0;
                    rsp_last_d = 1'b0;
                    state_d    = cmd_write_i ? WrReq : RdReq;
                end
            end
            WrReq: begin
                cfg_req_o     = wdata_valid_i;
                cfg_addr_o    = addr_q;
                cfg_wdata_o   = wdata_i;
                wdata_ready_o = wdata_valid_i && cfg_gnt_i;
                if (wdata_valid_i && cfg_gnt_i) begin
                    addr_d = addr_q + STRIDE;
                    if (cnt_q == '0) begin
                        rsp_data_d = '0;
                        rsp_last_d = 1'b1;
                        state_d    = Rsp;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (expire) begin
                    rsp_data_d = DATA_WIDTH'(CFG_ILLEGAL_DATA);
                    rsp_last_d = 1'b1;
                    state_d    = Rsp;
                end
            end
            RdReq: begin
                cfg_req_o  = 1'b1;
                cfg_wen_o  = 1'b1;
                cfg_addr_o = addr_q;
                if (cfg_gnt_i) begin
                    state_d = RdWait;
                end else if (expire) begin
                    rsp_data_d = DATA_WIDTH'(CFG_ILLEGAL_DATA);
                    rsp_last_d = 1'b1;
                    state_d    = Rsp;
                end
            end
            RdWait: begin
                if (cfg_rvalid_i) begin
                    rsp_data_d = cfg_rdata_i;
                    rsp_last_d = (cnt_q == '0);
                    state_d    = Rsp;
                end else if (expire) begin
                    rsp_data_d = DATA_WIDTH'(CFG_ILLEGAL_DATA);
                    rsp_last_d = 1'b1;
                    state_d    = Rsp;
                end
            end
            Rsp: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    if (rsp_last_q) begin
                        state_d = Idle;
                    end else begin
                        addr_d  = addr_q + STRIDE;
                        cnt_d   = cnt_q - 1'b1;
                        state_d = RdReq;
                    end
                end
            end
            default: state_d = Idle;
        endcase
    end

    assign rsp_data_o = rsp_data_q;
    assign rsp_last_o = rsp_last_q;
    assign busy_o     = (state_q != Idle);

endmodule

// File: tb/tb_cfg_master.sv
// Testbench for cfg_master: directed bursts against a command-level model
// (address list and response list per burst) plus literal expectations.
module tb_cfg_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [AW-1:0] cmd_addr_i;
    logic [LW-1:0] cmd_len_i;
    logic          wdata_valid_i, wdata_ready_o;
    logic [DW-1:0] wdata_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_last_o, rsp_err_o;
    logic [DW-1:0] rsp_data_o;
    logic          cfg_req_o, cfg_gnt_i, cfg_wen_o, cfg_rvalid_i, busy_o;
    logic [AW-1:0] cfg_addr_o;
    logic [DW-1:0] cfg_wdata_o, cfg_rdata_i;

    always #5 clk = ~clk;

    cfg_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_last_o(rsp_last_o), .rsp_err_o(rsp_err_o),
        .cfg_req_o(cfg_req_o), .cfg_gnt_i(cfg_gnt_i), .cfg_wen_o(cfg_wen_o),
        .cfg_addr_o(cfg_addr_o), .cfg_wdata_o(cfg_wdata_o), .cfg_rdata_i(cfg_rdata_i),
        .cfg_rvalid_i(cfg_rvalid_i), .busy_o(busy_o)
    );

    typedef struct packed { logic [AW-1:0] addr; logic wen; logic [DW-1:0] wdata; } req_t;
    typedef struct packed { logic [DW-1:0] data; logic last; logic err; } rsp_t;

    req_t          exp_req[$];
    rsp_t          exp_rsp[$];
    logic [DW-1:0] wq[$];
    logic [AW-1:0] req_addr_log[$];
    logic [DW-1:0] rsp_data_log[$];
    logic          rsp_last_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_cmd = -1, t_req = -1, t_gnt = -1, t_rsp = -1;
    int req_cycles = 0;
    int gnt_block = 0, rdy_block = 0;
    bit wgap = 0, rv_off = 0, rd_illegal = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Config unit contents as seen by reads: word index, or the illegal pattern
    function automatic logic [DW-1:0] resp_word(input logic [AW-1:0] a);
        return rd_illegal ? 32'hdeadda7a : DW'(a >> 2);
    endfunction

    // Environment: wdata source, combinational grant, read responder, response sink
    initial begin
        bit            wfire, rfire, sawreq, sawrsp, wtog;
        logic [AW-1:0] rv_addr;
        wtog = 0; rv_addr = '0;
        cfg_gnt_i = 1; cfg_rvalid_i = 0; cfg_rdata_i = '0;
        wdata_valid_i = 0; wdata_i = '0; rsp_ready_i = 1;
        forever begin
            @(negedge clk);
            wfire  = wdata_valid_i && wdata_ready_o;
            rfire  = cfg_req_o && cfg_gnt_i && cfg_wen_o;
            if (rfire) rv_addr = cfg_addr_o;
            sawreq = cfg_req_o;
            sawrsp = rsp_valid_o;
            @(posedge clk);
            #1;
            if (wfire && wq.size() > 0) void'(wq.pop_front());
            if (sawreq && gnt_block > 0) gnt_block--;
            if (sawrsp && rdy_block > 0) rdy_block--;
            cfg_gnt_i     = (gnt_block == 0);
            rsp_ready_i   = (rdy_block == 0);
            wtog          = ~wtog;
            wdata_valid_i = (wq.size() > 0) && (!wgap || wtog);
            wdata_i       = (wq.size() > 0) ? wq[0] : '0;
            cfg_rvalid_i  = rfire && !rv_off && rst_ni;
            cfg_rdata_i   = cfg_rvalid_i ? resp_word(rv_addr) : '0;
        end
    end

    // Compare process: checks every cfg and response handshake against the model
    initial begin
        bit   stall_pend, bp_pend;
        req_t stall_r, e;
        rsp_t bp_p, p;
        stall_pend = 0; bp_pend = 0; stall_r = '0; bp_p = '0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                stall_pend = 0;
                bp_pend    = 0;
                continue;
            end
            if (cmd_valid_i && cmd_ready_o) t_cmd = cyc;
            chk("busy_vs_ready", busy_o, !cmd_ready_o);
            chk("wdata_ready_rule", wdata_ready_o, cfg_req_o && !cfg_wen_o && cfg_gnt_i);
            if (cfg_req_o && !cfg_wen_o) chk("req_without_wdata", wdata_valid_i, 1);
            if (rsp_valid_o) chk("req_during_rsp", cfg_req_o, 0);
`ifndef CFG_MASTER_TIMEOUT_EN
            chk("err_tied_low", rsp_err_o, 0);
`endif
            if (stall_pend && cfg_req_o) begin
                chk("stall_addr_stable", cfg_addr_o, stall_r.addr);
                chk("stall_wen_stable", cfg_wen_o, stall_r.wen);
                chk("stall_wdata_stable", cfg_wdata_o, stall_r.wdata);
            end
            if (bp_pend) begin
                chk("bp_valid_held", rsp_valid_o, 1);
                chk("bp_data_stable", rsp_data_o, bp_p.data);
                chk("bp_last_stable", rsp_last_o, bp_p.last);
                chk("bp_err_stable", rsp_err_o, bp_p.err);
            end
            if (cfg_req_o) begin
                req_cycles++;
                if (t_req < 0) t_req = cyc;
            end
            if (cfg_req_o && cfg_gnt_i) begin
                t_gnt = cyc;
                req_addr_log.push_back(cfg_addr_o);
                if (exp_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: actual addr=%0h required none", cfg_addr_o);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_addr", cfg_addr_o, e.addr);
                    chk("req_wen", cfg_wen_o, e.wen);
                    if (!e.wen) chk("req_wdata", cfg_wdata_o, e.wdata);
                end
                stall_pend = 0;
            end else if (cfg_req_o) begin
                stall_pend = 1;
                stall_r    = '{addr: cfg_addr_o, wen: cfg_wen_o, wdata: cfg_wdata_o};
            end
            if (rsp_valid_o && t_rsp < 0) t_rsp = cyc;
            if (rsp_valid_o && rsp_ready_i) begin
                rsp_data_log.push_back(rsp_data_o);
                rsp_last_log.push_back(rsp_last_o);
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: actual data=%0h required none", rsp_data_o);
                end else begin
                    p = exp_rsp.pop_front();
                    chk("rsp_data", rsp_data_o, p.data);
                    chk("rsp_last", rsp_last_o, p.last);
                    chk("rsp_err", rsp_err_o, p.err);
                end
            end
            bp_pend = rsp_valid_o && !rsp_ready_i;
            bp_p    = '{data: rsp_data_o, last: rsp_last_o, err: rsp_err_o};
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
        chk({tag, "_rsp_data"}, rsp_data_o, 0);
        chk({tag, "_rsp_last"}, rsp_last_o, 0);
        chk({tag, "_rsp_err"}, rsp_err_o, 0);
        chk({tag, "_cfg_req"}, cfg_req_o, 0);
        chk({tag, "_cfg_wen"}, cfg_wen_o, 0);
        chk({tag, "_cfg_addr"}, cfg_addr_o, 0);
        chk({tag, "_cfg_wdata"}, cfg_wdata_o, 0);
        chk({tag, "_wdata_ready"}, wdata_ready_o, 0);
    endtask

    task automatic clear_logs();
        req_addr_log.delete();
        rsp_data_log.delete();
        rsp_last_log.delete();
        req_cycles = 0;
        t_cmd = -1; t_req = -1; t_gnt = -1; t_rsp = -1;
    endtask

    // Build the expected transaction list for one burst, then issue the command
    task automatic send(input bit wr, input logic [AW-1:0] a, input int len,
                        input logic [DW-1:0] seed, input bit tmo);
        logic [AW-1:0] base, ad;
        req_t r;
        rsp_t p;
        int   n;
        base = {a[AW-1:2], 2'b00};
        for (int i = 0; i <= len; i++) begin
            ad = base + AW'(i * 4);
            if (!tmo || i == 0) begin
                r.addr  = ad;
                r.wen   = !wr;
                r.wdata = wr ? seed + DW'(i) : '0;
                exp_req.push_back(r);
            end
            if (wr) wq.push_back(seed + DW'(i));
            else if (!tmo) begin
                p.data = resp_word(ad); p.last = (i == len); p.err = 0;
                exp_rsp.push_back(p);
            end
        end
        if (tmo) begin
            p.data = 32'hdeadda7a; p.last = 1; p.err = 1; exp_rsp.push_back(p);
        end else if (wr) begin
            p.data = '0; p.last = 1; p.err = 0; exp_rsp.push_back(p);
        end
        @(posedge clk); #2;
        cmd_write_i = wr; cmd_addr_i = a; cmd_len_i = LW'(len); cmd_valid_i = 1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (cmd_ready_o) break;
        end
        chk("cmd_accept_in_budget", n < 100, 1);
        @(posedge clk); #2;
        cmd_valid_i = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (!busy_o && exp_req.size() == 0 && exp_rsp.size() == 0) break;
        end
        chk({tag, "_done_in_budget"}, n < budget, 1);
        chk({tag, "_reqs_left"}, exp_req.size(), 0);
        chk({tag, "_rsps_left"}, exp_rsp.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=stuck required=finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [AW-1:0] burst_addr[4];
        logic [DW-1:0] burst_data[4];
        int n;
        rst_ni = 0; cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0; cmd_len_i = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #2;
        rst_ni = 1;
        repeat (2) @(posedge clk);

        // Single write, grant always present
        clear_logs();
        send(1, 16'h2000, 0, 32'hA5A5_0001, 0);
        wait_done("single_wr", 200);
        chk("single_wr_req_cycles", req_cycles, 1);
        chk("single_wr_req_count", req_addr_log.size(), 1);
        if (req_addr_log.size() == 1) chk("single_wr_addr", req_addr_log[0], 16'h2000);
        chk("single_wr_rsp_count", rsp_data_log.size(), 1);
        if (rsp_data_log.size() == 1) begin
            chk("single_wr_rsp_data", rsp_data_log[0], 0);
            chk("single_wr_rsp_last", rsp_last_log[0], 1);
        end

        // Single read latency: req at T+1, rsp_valid at T+3
        clear_logs();
        send(0, 16'h0100, 0, '0, 0);
        wait_done("latency", 200);
        chk("latency_req", t_req - t_cmd, 1);
        chk("latency_rsp", t_rsp - t_cmd, 3);
        if (rsp_data_log.size() == 1) chk("latency_data", rsp_data_log[0], 32'h40);

        // Read burst across the 0x4000 boundary
        clear_logs();
        burst_addr = '{16'h3FF8, 16'h3FFC, 16'h4000, 16'h4004};
        burst_data = '{32'h0FFE, 32'h0FFF, 32'h1000, 32'h1001};
        send(0, 16'h3FF8, 3, '0, 0);
        wait_done("rd_burst", 400);
        chk("rd_burst_count", rsp_data_log.size(), 4);
        if (rsp_data_log.size() == 4 && req_addr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("rd_burst_lit_addr", req_addr_log[i], burst_addr[i]);
                chk("rd_burst_lit_data", rsp_data_log[i], burst_data[i]);
                chk("rd_burst_lit_last", rsp_last_log[i], i == 3);
            end
        end

        // Response backpressure for 5 cycles on the first beat
        clear_logs();
        rdy_block = 5;
        send(0, 16'h1000, 2, '0, 0);
        wait_done("backpressure", 400);
        chk("bp_rsp_count", rsp_data_log.size(), 3);

        // Grant stall plus wdata gaps on a write burst
        clear_logs();
        wgap = 1;
        gnt_block = 3;
        send(1, 16'h0040, 3, 32'h1111_0000, 0);
        wait_done("gnt_stall", 400);
        wgap = 0;
        chk("gnt_stall_req_count", req_addr_log.size(), 4);
        if (req_addr_log.size() == 4) chk("gnt_stall_last_addr", req_addr_log[3], 16'h004C);
        chk("gnt_stall_wq_drained", wq.size(), 0);

        // Address wrap, low address bits ignored
        clear_logs();
        send(1, 16'hFFFF, 1, 32'h0000_BEEF, 0);
        wait_done("wrap", 200);
        chk("wrap_req_count", req_addr_log.size(), 2);
        if (req_addr_log.size() == 2) begin
            chk("wrap_addr0", req_addr_log[0], 16'hFFFC);
            chk("wrap_addr1", req_addr_log[1], 16'h0000);
        end

        // Illegal-address pattern passes through unflagged
        clear_logs();
        rd_illegal = 1;
        send(0, 16'h0200, 1, '0, 0);
        wait_done("illegal", 200);
        rd_illegal = 0;
        if (rsp_data_log.size() == 2) chk("illegal_data", rsp_data_log[1], 32'hdeadda7a);

        // Maximal length: 256 beats
        clear_logs();
        send(0, 16'h0000, 255, '0, 0);
        wait_done("maxlen", 3000);
        chk("maxlen_rsp_count", rsp_data_log.size(), 256);
        if (req_addr_log.size() == 256) chk("maxlen_last_addr", req_addr_log[255], 16'h03FC);

        // Reset while waiting for read data
        clear_logs();
        rv_off = 1;
        send(0, 16'h0500, 2, '0, 0);
        n = 0;
        while (exp_req.size() != 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_first_gnt_seen", n < 100, 1);
        @(posedge clk); #2;
        chk("rst_in_rdwait_busy", busy_o, 1);
        chk("rst_in_rdwait_noreq", cfg_req_o, 0);
        rst_ni = 0;
        #1;
        check_reset_outputs("midrst");
        exp_req.delete();
        exp_rsp.delete();
        rv_off = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_ni = 1;
        repeat (5) @(negedge clk);
        chk("midrst_no_rsp", rsp_data_log.size(), 0);
        send(0, 16'h0600, 0, '0, 0);
        wait_done("after_rst", 200);

`ifdef CFG_MASTER_TIMEOUT_EN
        // Watchdog: rvalid never returns
        clear_logs();
        rv_off = 1;
        send(0, 16'h0700, 2, '0, 1);
        wait_done("timeout", 400);
        rv_off = 0;
        chk("timeout_rdwait_cycles", t_rsp - t_gnt, 65);
        chk("timeout_req_count", req_addr_log.size(), 1);
        chk("timeout_idle", busy_o, 0);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_master.md
Name: cfg_master

Overview:
- Initiator for the sequencer config interface (cfg_req/gnt/wen/addr/wdata/rdata/rvalid). Drives the config unit from the host-side frontend, e.g. the SPI/debug deserializer.
- Turns one burst command on a valid/ready stream into a sequence of single-word cfg transactions. Addresses auto-increment by 4.
- Returns read data, or one write acknowledge, on a response stream. Only one cfg transaction is in flight at a time.

Parameters:
- ADDR_WIDTH, 16, cfg address width (matches cfg_addr_t).
- DATA_WIDTH, 32, cfg data width (matches word_t).
- LEN_WIDTH, 8, burst length field; a value of N means N+1 beats.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted. High only in IDLE.
- cmd_write_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  ADDR_WIDTH  start byte address; bits [1:0] are ignored (forced to 0).
- cmd_len_i  in  LEN_WIDTH  number of beats minus 1.
- wdata_valid_i  in  1  write beat valid.
- wdata_ready_o  out  1  write beat consumed.
- wdata_i  in  DATA_WIDTH  write beat data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_data_o  out  DATA_WIDTH  read data; 0 for a write ack.
- rsp_last_o  out  1  final response of the burst.
- rsp_err_o  out  1  burst aborted (optional feature only; otherwise tied 0).
- cfg_req_o  out  1  cfg request.
- cfg_gnt_i  in  1  cfg grant, combinational in the same cycle as req.
- cfg_wen_o  out  1  1 = read, 0 = write (active-low write enable).
- cfg_addr_o  out  ADDR_WIDTH  cfg address.
- cfg_wdata_o  out  DATA_WIDTH  cfg write data.
- cfg_rdata_i  in  DATA_WIDTH  cfg read data.
- cfg_rvalid_i  in  1  read data valid, one or more cycles after gnt.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: state IDLE. All outputs 0, except cmd_ready_o=1. Address, beat counter and response registers are cleared to 0. A reset mid-burst abandons the burst and emits no response.
- IDLE: on cmd_valid_i, latch the write flag, address (with [1:0]=0) and beat counter = cmd_len_i. Go to WR_REQ or RD_REQ.
- WR_REQ:
  - cfg_req_o = wdata_valid_i, cfg_wen_o=0, cfg_wdata_o = wdata_i, cfg_addr_o = current address.
  - wdata_ready_o = wdata_valid_i & cfg_gnt_i. req is never raised without valid data.
  - On a grant: address += 4, counter -= 1. If that was the last beat, go to RSP with data=0, last=1.
- RD_REQ: cfg_req_o=1, cfg_wen_o=1. Hold req, addr and wen stable until cfg_gnt_i, then go to RD_WAIT.
- RD_WAIT: req deasserted. On cfg_rvalid_i, register cfg_rdata_i; last = (counter==0); go to RSP.
- RSP:
  - rsp_valid_o=1, with data, last and err stable until rsp_ready_i.
  - On handshake: if last, go to IDLE. Otherwise address += 4, counter -= 1, go to RD_REQ.
  - No cfg traffic occurs while in RSP.
- Address arithmetic is modulo 2^ADDR_WIDTH; 0xFFFC + 4 wraps to 0x0000.
- Latency, single read with gnt in the same cycle and rvalid one cycle later: cmd handshake at T, req at T+1, rvalid at T+2, rsp_valid at T+3.
- Read data 0xdeadda7a (the illegal-address pattern) is passed through unmodified and is not flagged.
- cmd_len_i is maximal (2^LEN_WIDTH−1): 2^LEN_WIDTH beats are issued, with no counter overflow.

Optional Feature:
- CFG_MASTER_TIMEOUT_EN defined:
  - A watchdog counts consecutive cycles spent in WR_REQ with req high and no gnt, in RD_REQ without gnt, or in RD_WAIT without rvalid.
  - The count resets on any progress.
  - When the count reaches TIMEOUT_CYCLES: drop req, go to RSP with data=32'hdeadda7a, err=1, last=1. The remaining beats are not issued and unconsumed wdata beats are left for upstream to flush.
  - WR_REQ with wdata_valid_i low does not count.
- Undefined: no watchdog logic; rsp_err_o is tied to 0; a missing gnt/rvalid stalls indefinitely.

Decomposition:
- Package pkg_cfg_master:
  - state enum {Idle, WrReq, RdReq, RdWait, Rsp};
  - cfg_len_t;
  - CFG_ILLEGAL_DATA = 32'hdeadda7a, shared with the config unit;
  - CFG_ADDR_STRIDE = 4.
- cfg_addr_t and word_t are reused from pkg_common.
- Optional sub-module cfg_master_watchdog: counter, clear, expire.

Test Plan:
- Single write: cmd{write=1, addr=0x2000, len=0}, wdata=0xA5A5_0001, gnt tied 1 → exactly one req cycle with wen=0, addr 0x2000; then one rsp{data=0, last=1}.
- Read burst: cmd{write=0, addr=0x3FF8, len=3}, responder returns addr>>2 → reqs at 0x3FF8, 0x3FFC, 0x4000, 0x4004; rsp data 0xFFE, 0xFFF, 0x1000, 0x1001; last only on the 4th.
- Backpressure: rsp_ready_i held low for 5 cycles on beat 1 → no new req during the stall, rsp_data_o stable, burst still completes in order.
- Gnt stall plus wdata gaps: gnt low for 3 cycles, wdata_valid toggling → req/addr/wdata stable while stalled, wdata_ready only on gnt, no lost or duplicated beat.
- Wrap and reset: cmd addr=0xFFFC, len=1 → reqs at 0xFFFC then 0x0000. Assert rst_ni in RD_WAIT → all outputs back to reset values next edge, no rsp.
- Timeout (macro on, TIMEOUT_CYCLES=64): read with rvalid never asserted → rsp{data=0xdeadda7a, err=1, last=1} after 64 RD_WAIT cycles, then IDLE.
